// File: rtl/mac_rr_scheduler.sv
// mac_rr_scheduler
// Shares one 3-beat multiply-accumulate unit (result = a*b+c) between NREQ
// requesters. Jobs are granted in round-robin order. The winner's operands are
// latched and streamed to the MAC as a, b, c on three back-to-back cycles. The
// scheduler then waits for the result, or for a timeout, and returns the result
// tagged with the requester id.
//
// Ports
//   clk, rst      clock (rising edge); asynchronous active-high reset
//   req_valid     per-requester job request; held with operands stable until granted
//   req_ready     one-hot, 1-cycle grant pulse (IDLE only); operands latched at that edge
//   req_a/b/c     packed operands, requester i uses slice [i*W +: W]
//   mac_validi    beat valid towards the MAC
//   mac_data_in   beat data: a, then b, then c (0 when no beat)
//   mac_valido    MAC result valid (only honoured in WAIT)
//   mac_data_out  MAC result
//   rsp_valid     response available, held until rsp_ready
//   rsp_ready     consumer accepts the response
//   rsp_id        requester id of the response
//   rsp_data      result (0 when rsp_err=1)
//   rsp_err       1 = MAC did not answer within TIMEOUT cycles in WAIT
//   dbg_state     current FSM state (IDLE=0 SEND_A=1 SEND_B=2 SEND_C=3 WAIT=4 RESP=5)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. On the request side, req_ready is a combinational pulse for the winner
// only while IDLE. On the response side, rsp_valid/rsp_id/rsp_data/rsp_err stay
// stable until the edge where rsp_ready is seen. The MAC side has no
// back-pressure: beats are never stalled, and a result is taken on the first
// mac_valido seen in WAIT.

module mac_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  input  logic [NREQ*W-1:0]         req_c,
  output logic                      mac_validi,
  output logic [W-1:0]              mac_data_in,
  input  logic                      mac_valido,
  input  logic [W-1:0]              mac_data_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [W-1:0]              rsp_data,
  output logic                      rsp_err,
  output logic [2:0]                dbg_state
);

  localparam int IDW = $clog2(NREQ);
  // Wide enough to hold TIMEOUT-1 with headroom.
  localparam int TW  = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    SEND_C = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nx;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic [W-1:0]   a_q, b_q, c_q;
  logic [TW-1:0]  tmo_cnt;
  logic           grant;
  logic           wait_done;
  logic           timed_out;

  assign dbg_state = state;

  // Round-robin search: the first requester at or after ptr, wrapping mod NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req_valid[IDW'(idx)]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  assign ptr_nx = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
  assign grant  = (state == IDLE) && win_found;

  // Gated by rst so that every output reads 0 while reset is held.
  assign req_ready = (grant && !rst) ? (NREQ'(1) << win_id) : '0;

  // A result takes priority over a timeout that lands on the same cycle.
  assign timed_out = (tmo_cnt == TW'(TIMEOUT - 1)) && !mac_valido;
  assign wait_done = mac_valido || timed_out;

  // Next state and MAC-side outputs.
  always_comb begin
    state_nx    = state;
    mac_validi  = 1'b0;
    mac_data_in = '0;
    case (state)
      IDLE: begin
        if (win_found) state_nx = SEND_A;
      end
      SEND_A: begin
        mac_validi  = 1'b1;
        mac_data_in = a_q;
        state_nx    = SEND_B;
      end
      SEND_B: begin
        mac_validi  = 1'b1;
        mac_data_in = b_q;
        state_nx    = SEND_C;
      end
      SEND_C: begin
        mac_validi  = 1'b1;
        mac_data_in = c_q;
        state_nx    = WAIT;
      end
      WAIT: begin
        if (wait_done) state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Job capture at grant. Non-winners are left untouched and keep waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= '0;
      id_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
    end else if (grant) begin
      ptr  <= ptr_nx;
      id_q <= win_id;
      a_q  <= req_a[int'(win_id)*W +: W];
      b_q  <= req_b[int'(win_id)*W +: W];
      c_q  <= req_c[int'(win_id)*W +: W];
    end
  end

  // WAIT cycle counter. It is 0 on the first WAIT cycle and counts up while
  // the FSM stays in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == WAIT && !wait_done) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Response register. It is loaded on leaving WAIT and drops valid on the
  // accepting edge. id/data/err keep their last values while valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == WAIT && wait_done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_err   <= !mac_valido;
        rsp_data  <= mac_valido ? mac_data_out : '0;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Directed testbench for mac_rr_scheduler (NREQ=4, W=32, TIMEOUT=16).
// A behavioural MAC model answers a*b+c after a configurable latency, or never.
// Expected grants, MAC beats and responses are queued when a job is set up.
// A monitor running on the falling edge pops and compares them.

module tb_mac_rr_scheduler;

  localparam int NREQ    = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a, req_b, req_c;
  logic              mac_validi;
  logic [W-1:0]      mac_data_in;
  logic              mac_valido;
  logic [W-1:0]      mac_data_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic [2:0]        dbg_state;

  mac_rr_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_c        (req_c),
    .mac_validi   (mac_validi),
    .mac_data_in  (mac_data_in),
    .mac_valido   (mac_valido),
    .mac_data_out (mac_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .dbg_state    (dbg_state)
  );

  localparam logic [2:0] S_IDLE = 3'd0, S_SEND_B = 3'd2, S_WAIT = 3'd4, S_RESP = 3'd5;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;

  logic [1:0]   grant_q[$];
  logic [W-1:0] beat_q[$];
  logic [W+2:0] exp_q[$];     // {err, id, data}
  int           grant_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic expect_job(input logic [1:0] id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] res, input logic err);
    grant_q.push_back(id);
    beat_q.push_back(a);
    beat_q.push_back(b);
    beat_q.push_back(c);
    exp_q.push_back({err, id, res});
  endtask

  // Monitor: the falling edge sits away from the active edge, and inputs only
  // change just after the rising edge.
  logic [1:0]   mon_g;
  logic [W-1:0] mon_beat;
  logic [W+2:0] mon_rsp;
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != '0) begin
        grant_cyc_q.push_back(cyc);
        if (grant_q.size() == 0) begin
          checks++;
          $display("FAIL grant_unexpected: got req_ready=%b expected no grant", req_ready);
        end else begin
          mon_g = grant_q.pop_front();
          check("grant", req_ready, NREQ'(1) << mon_g);
        end
      end
      if (mac_validi) begin
        if (beat_q.size() == 0) begin
          checks++;
          $display("FAIL beat_unexpected: got beat 0x%0h expected none", mac_data_in);
        end else begin
          mon_beat = beat_q.pop_front();
          check("mac_beat", mac_data_in, mon_beat);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL rsp_unexpected: got id=%0d data=0x%0h err=%0b expected none",
                   rsp_id, rsp_data, rsp_err);
        end else begin
          mon_rsp = exp_q.pop_front();
          check("rsp {err,id,data}", {rsp_err, rsp_id, rsp_data}, mon_rsp);
        end
      end
    end
  end

  // ---------------- MAC model ----------------
  logic         mac_en;
  int           mac_lat;
  logic [W-1:0] mb[3];
  int           nb = 0;
  logic         pend = 1'b0;
  int           dly = 0;
  logic [W-1:0] mres;

  always @(negedge clk) begin
    if (!rst && mac_validi) begin
      mb[nb] = mac_data_in;
      nb++;
      if (nb == 3) begin
        nb = 0;
        if (mac_en) begin
          pend = 1'b1;
          dly  = mac_lat;
          mres = mb[0] * mb[1] + mb[2];
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    mac_valido   = 1'b0;
    mac_data_out = 32'hDEAD_BEEF;   // junk when not valid
    if (pend) begin
      dly--;
      if (dly <= 0) begin
        mac_valido   = 1'b1;
        mac_data_out = mres;
        pend         = 1'b0;
      end
    end
  end

  always @(posedge rst) begin
    nb   = 0;
    pend = 1'b0;
  end

  // ---------------- requester driver ----------------
  // A requester drops req_valid right after the edge where its grant was seen.
  logic [NREQ-1:0] ready_seen = '0;
  always @(negedge clk) ready_seen = req_ready;
  always @(posedge clk) begin
    #1;
    req_valid  = req_valid & ~ready_seen;
    ready_seen = '0;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
    req_valid[i]    = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!(grant_q.size() == 0 && beat_q.size() == 0 && exp_q.size() == 0 &&
             req_valid == '0 && dbg_state == S_IDLE) && t < 400) begin
      step(1);
      t++;
    end
    if (t >= 400) begin
      checks++;
      $display("FAIL %s: timed out draining (grants %0d beats %0d rsps %0d left)",
               name, grant_q.size(), beat_q.size(), exp_q.size());
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int t;
    t = 0;
    while (dbg_state != s && t < 200) begin
      step(1);
      t++;
    end
    if (t >= 200) begin
      checks++;
      $display("FAIL %s: timed out waiting for state %0d, got %0d", name, s, dbg_state);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},   req_ready,   '0);
    check({tag, " mac_validi"},  mac_validi,  '0);
    check({tag, " mac_data_in"}, mac_data_in, '0);
    check({tag, " rsp_valid"},   rsp_valid,   '0);
    check({tag, " rsp_id"},      rsp_id,      '0);
    check({tag, " rsp_data"},    rsp_data,    '0);
    check({tag, " rsp_err"},     rsp_err,     '0);
    check({tag, " state"},       dbg_state,   S_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst          = 1'b1;
    req_valid    = '0;
    req_a        = '0;
    req_b        = '0;
    req_c        = '0;
    rsp_ready    = 1'b1;
    mac_en       = 1'b1;
    mac_lat      = 1;
    mac_valido   = 1'b0;
    mac_data_out = '0;
    step(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    step(1);

    // Single job on req0: 3*4+5 = 17
    expect_job(2'd0, 32'd3, 32'd4, 32'd5, 32'd17, 1'b0);
    issue(0, 32'd3, 32'd4, 32'd5);
    wait_done("single_req0");

    // Wrap: 0x10000*0x10000 + 1 = 2^32 + 1 -> 1
    expect_job(2'd0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd1, 1'b0);
    issue(0, 32'h0001_0000, 32'h0001_0000, 32'd1);
    wait_done("wrap");

    // Reset while idle brings ptr back to 0 (it is 1 here).
    rst = 1'b1;
    step(1);
    check_reset_outputs("reset2");
    rst = 1'b0;
    step(1);

    // All four requesting: order 0,1,2,3, one grant every 6 cycles.
    grant_cyc_q.delete();
    expect_job(2'd0, 32'd1,   32'd2,  32'd3,  32'd5,   1'b0);
    expect_job(2'd1, 32'd10,  32'd20, 32'd30, 32'd230, 1'b0);
    expect_job(2'd2, 32'd100, 32'd3,  32'd7,  32'd307, 1'b0);
    expect_job(2'd3, 32'd0,   32'd5,  32'd9,  32'd9,   1'b0);
    issue(0, 32'd1,   32'd2,  32'd3);
    issue(1, 32'd10,  32'd20, 32'd30);
    issue(2, 32'd100, 32'd3,  32'd7);
    issue(3, 32'd0,   32'd5,  32'd9);
    wait_done("all_four");
    check("grant_count", grant_cyc_q.size(), 4);
    for (int k = 0; k + 1 < grant_cyc_q.size(); k++)
      check("grant_period", grant_cyc_q[k+1] - grant_cyc_q[k], 6);

    // ptr is back at 0; only req1 and req2 request -> 1 then 2.
    expect_job(2'd1, 32'd2, 32'd2, 32'd2, 32'd6,  1'b0);
    expect_job(2'd2, 32'd3, 32'd3, 32'd3, 32'd12, 1'b0);
    issue(1, 32'd2, 32'd2, 32'd2);
    issue(2, 32'd3, 32'd3, 32'd3);
    wait_done("req1_req2");

    // Back-pressure: ptr=3, so req3 wins first; req2 waits behind a held response.
    rsp_ready = 1'b0;
    expect_job(2'd3, 32'd7,         32'd6, 32'd1, 32'd43, 1'b0);
    expect_job(2'd2, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'd3,  1'b0);
    issue(3, 32'd7, 32'd6, 32'd1);
    issue(2, 32'hFFFF_FFFF, 32'd2, 32'd5);
    wait_state(S_RESP, "hold_enter_resp");
    for (int k = 0; k < 5; k++) begin
      check("hold rsp_valid",  rsp_valid,  1'b1);
      check("hold rsp_id",     rsp_id,     2'd3);
      check("hold rsp_data",   rsp_data,   32'd43);
      check("hold req_ready",  req_ready,  '0);
      check("hold mac_validi", mac_validi, 1'b0);
      step(1);
    end
    rsp_ready = 1'b1;
    wait_done("hold");

    // Timeout: the MAC never answers, so WAIT lasts TIMEOUT cycles and the
    // response is an error.
    mac_en = 1'b0;
    expect_job(2'd0, 32'd9, 32'd9, 32'd9, 32'd0, 1'b1);
    issue(0, 32'd9, 32'd9, 32'd9);
    wait_state(S_WAIT, "timeout_enter_wait");
    check("wait mac_validi",  mac_validi,  1'b0);
    check("wait mac_data_in", mac_data_in, '0);
    n = 0;
    while (dbg_state == S_WAIT && n < 100) begin
      n++;
      step(1);
    end
    check("timeout_wait_cycles", n, TIMEOUT);
    wait_done("timeout");
    mac_en = 1'b1;
    expect_job(2'd1, 32'd2, 32'd3, 32'd4, 32'd10, 1'b0);
    issue(1, 32'd2, 32'd3, 32'd4);
    wait_done("after_timeout");

    // Reset during SEND_B: the job is dropped and ptr (here 2) returns to 0.
    expect_job(2'd2, 32'd10, 32'd10, 32'd10, 32'd110, 1'b0);
    issue(2, 32'd10, 32'd10, 32'd10);
    wait_state(S_SEND_B, "midjob_enter_send_b");
    rst = 1'b1;
    #1;
    check("midrst mac_validi", mac_validi, 1'b0);
    check("midrst rsp_valid",  rsp_valid,  1'b0);
    check("midrst state",      dbg_state,  S_IDLE);
    step(1);
    rst = 1'b0;
    beat_q.delete();
    exp_q.delete();
    grant_q.delete();
    step(3);
    check("post_rst rsp_valid",  rsp_valid,  1'b0);
    check("post_rst mac_validi", mac_validi, 1'b0);
    expect_job(2'd1, 32'd1, 32'd1, 32'd1, 32'd2, 1'b0);
    expect_job(2'd3, 32'd2, 32'd2, 32'd2, 32'd6, 1'b0);
    issue(1, 32'd1, 32'd1, 32'd1);
    issue(3, 32'd2, 32'd2, 32'd2);
    wait_done("after_midjob_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
